// File: rtl/drm_arb_pkg.sv
// Shared types and helpers for the DRM simple-dual-port arbiter.
// Holds the FSM state encoding, the read-tag struct and latency/ID-width helpers.
package drm_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int MAX_ID_W = 3;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Read tag travelling alongside the RAM read latency
   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

   // RD_LAT = 1 + OUTPUT_REG
   function automatic int arb_rd_lat(input int output_reg);
      return 1 + output_reg;
   endfunction

   // ID_W = clog2(NUM_REQ), at least one bit
   function automatic int arb_id_w(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/drm_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
// Ports: req (per requester), ptr (start index) -> grant (one-hot/zero), grant_idx.
module drm_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   // Scan downward from ptr+NUM_REQ-1 so the nearest request at/after ptr wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int p = 0; p < NUM_REQ; p++) begin
         if (ptr == ID_W'(p)) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
               if (req[(p + k) % NUM_REQ]) begin
                  grant                    = '0;
                  grant[(p + k) % NUM_REQ] = 1'b1;
                  grant_idx                = ID_W'((p + k) % NUM_REQ);
               end
            end
         end
      end
   end

endmodule

// File: rtl/drm_sdp_port_arbiter.sv
// Shares one simple-dual-port DRM RAM between NUM_REQ requesters with
// independent round-robin arbitration on the write and read ports.
// Ports: wr_*/rd_* packed per-requester requests with valid/ready, rsp_valid
// (one-hot pulse) + rsp_data, init_done, ram_* to/from the RAM instance.
// Option: DRM_ARB_COLLISION_STALL_EN withholds a read whose address equals
// the same-cycle write address, so the read returns the new data.
module drm_sdp_port_arbiter
   import drm_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_WIDTH   = 7,
   parameter int DATA_WIDTH   = 8,
   parameter int BE_WIDTH     = 1,
   parameter int OUTPUT_REG   = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            wr_valid,
   output logic [NUM_REQ-1:0]            wr_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_REQ*BE_WIDTH-1:0]   wr_byte_en,
   input  logic [NUM_REQ-1:0]            rd_valid,
   output logic [NUM_REQ-1:0]            rd_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          init_done,
   output logic                          ram_wr_en,
   output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
   output logic [DATA_WIDTH-1:0]         ram_wr_data,
   output logic [BE_WIDTH-1:0]           ram_wr_byte_en,
   output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

   localparam int RD_LAT = arb_rd_lat(OUTPUT_REG);
   localparam int ID_W   = arb_id_w(NUM_REQ);

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [ID_W-1:0]       wr_ptr, rd_ptr, wr_idx, rd_idx;
   logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;
   logic                  run, collide, wr_fire, rd_fire;
   logic [ADDR_WIDTH-1:0] wa [NUM_REQ];
   logic [ADDR_WIDTH-1:0] ra [NUM_REQ];
   logic [DATA_WIDTH-1:0] wd [NUM_REQ];
   logic [BE_WIDTH-1:0]   wb [NUM_REQ];
   tag_t                  pipe [RD_LAT];
   tag_t                  tag_in;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         wa[i] = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         ra[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         wd[i] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         wb[i] = wr_byte_en[i*BE_WIDTH +: BE_WIDTH];
      end
   end

   drm_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_wr_arb (
      .req       (wr_valid),
      .ptr       (wr_ptr),
      .grant     (wr_gnt),
      .grant_idx (wr_idx)
   );

   drm_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rd_arb (
      .req       (rd_valid),
      .ptr       (rd_ptr),
      .grant     (rd_gnt),
      .grant_idx (rd_idx)
   );

   // Grants are masked while clearing and while rst is asserted
   assign run = (state == S_RUN) && !rst;

`ifdef DRM_ARB_COLLISION_STALL_EN
   assign collide = (|wr_gnt) && (|rd_gnt) && (wa[wr_idx] == ra[rd_idx]);
`else
   assign collide = 1'b0;
`endif

   assign wr_ready = run ? wr_gnt : '0;
   assign rd_ready = (run && !collide) ? rd_gnt : '0;
   assign wr_fire  = |wr_ready;
   assign rd_fire  = |rd_ready;
   assign rsp_data = ram_rd_data;

   always_comb begin
      tag_in       = '0;
      tag_in.valid = rd_fire;
      tag_in.id    = MAX_ID_W'(rd_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= (CLEAR_ON_RST != 0) ? S_INIT : S_RUN;
         init_done      <= (CLEAR_ON_RST == 0);
         clr_cnt        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         ram_wr_en      <= 1'b0;
         ram_wr_addr    <= '0;
         ram_wr_data    <= '0;
         ram_wr_byte_en <= '0;
         ram_rd_addr    <= '0;
         rsp_valid      <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         // Tag shifts in lockstep with the RAM read latency
         pipe[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
         rsp_valid <= pipe[RD_LAT-1].valid
                      ? (NUM_REQ'(1) << pipe[RD_LAT-1].id) : '0;
         ram_wr_en <= 1'b0;
         unique case (state)
            S_INIT: begin
               ram_wr_en      <= 1'b1;
               ram_wr_addr    <= clr_cnt;
               ram_wr_data    <= '0;
               ram_wr_byte_en <= '1;
               clr_cnt        <= clr_cnt + 1'b1;
               if (&clr_cnt) begin
                  state     <= S_RUN;
                  init_done <= 1'b1;
               end
            end
            S_RUN: begin
               if (wr_fire) begin
                  ram_wr_en      <= 1'b1;
                  ram_wr_addr    <= wa[wr_idx];
                  ram_wr_data    <= wd[wr_idx];
                  ram_wr_byte_en <= wb[wr_idx];
                  wr_ptr <= (wr_idx == ID_W'(NUM_REQ-1)) ? '0 : wr_idx + 1'b1;
               end
               if (rd_fire) begin
                  ram_rd_addr <= ra[rd_idx];
                  rd_ptr <= (rd_idx == ID_W'(NUM_REQ-1)) ? '0 : rd_idx + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drm_sdp_port_arbiter.sv
// Directed testbench for drm_sdp_port_arbiter with behavioural RAM models.
// u0: 2 requesters, OUTPUT_REG=0, CLEAR_ON_RST=1; u1: 3 requesters, OUTPUT_REG=1, no clear.
module tb_drm_sdp_port_arbiter;

   typedef struct {
      int         c;
      logic [2:0] v;
      logic [7:0] d;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0;
   int errs = 0;

   logic [1:0]  wr_valid0 = '0, rd_valid0 = '0, wr_be0 = '1;
   logic [1:0]  wr_ready0, rd_ready0, rsp_valid0;
   logic [13:0] wr_addr0 = '0, rd_addr0 = '0;
   logic [15:0] wr_data0 = '0;
   logic [7:0]  rsp_data0, ram_wr_data0, ram_rd_data0, rq0;
   logic [6:0]  ram_wr_addr0, ram_rd_addr0;
   logic        ram_wr_en0, init_done0;
   logic [0:0]  ram_wr_be0;

   logic [2:0]  wr_valid1 = '0, rd_valid1 = '0, wr_be1 = '1;
   logic [2:0]  wr_ready1, rd_ready1, rsp_valid1;
   logic [20:0] wr_addr1 = '0, rd_addr1 = '0;
   logic [23:0] wr_data1 = '0;
   logic [7:0]  rsp_data1, ram_wr_data1, ram_rd_data1, rq1a, rq1b;
   logic [6:0]  ram_wr_addr1, ram_rd_addr1;
   logic        ram_wr_en1, init_done1;
   logic [0:0]  ram_wr_be1;

   drm_sdp_port_arbiter #(
      .NUM_REQ(2), .ADDR_WIDTH(7), .DATA_WIDTH(8), .BE_WIDTH(1),
      .OUTPUT_REG(0), .CLEAR_ON_RST(1)
   ) u0 (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid0), .wr_ready(wr_ready0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .wr_byte_en(wr_be0),
      .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_addr(rd_addr0),
      .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .init_done(init_done0),
      .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0),
      .ram_wr_data(ram_wr_data0), .ram_wr_byte_en(ram_wr_be0),
      .ram_rd_addr(ram_rd_addr0), .ram_rd_data(ram_rd_data0)
   );

   drm_sdp_port_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(7), .DATA_WIDTH(8), .BE_WIDTH(1),
      .OUTPUT_REG(1), .CLEAR_ON_RST(0)
   ) u1 (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .wr_byte_en(wr_be1),
      .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_addr(rd_addr1),
      .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .init_done(init_done1),
      .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1),
      .ram_wr_data(ram_wr_data1), .ram_wr_byte_en(ram_wr_be1),
      .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1)
   );

   // Old-data-on-collision RAM models
   logic [7:0] mem0 [128];
   logic [7:0] mem1 [128];
   always @(posedge clk) begin
      if (ram_wr_en0 && ram_wr_be0[0]) mem0[ram_wr_addr0] <= ram_wr_data0;
      rq0 <= mem0[ram_rd_addr0];
      if (ram_wr_en1 && ram_wr_be1[0]) mem1[ram_wr_addr1] <= ram_wr_data1;
      rq1a <= mem1[ram_rd_addr1];
      rq1b <= rq1a;
   end
   assign ram_rd_data0 = rq0;
   assign ram_rd_data1 = rq1b;

   rsp_t q0[$], q1[$], e[$];
   rsp_t m0, m1;
   always @(negedge clk) begin
      if (|rsp_valid0) begin
         m0.c = cyc; m0.v = {1'b0, rsp_valid0}; m0.d = rsp_data0;
         q0.push_back(m0);
      end
      if (|rsp_valid1) begin
         m1.c = cyc; m1.v = rsp_valid1; m1.d = rsp_data1;
         q1.push_back(m1);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      wr_valid0 = 2'b11; rd_valid0 = 2'b11;
      wr_valid1 = 3'b100; rd_valid1 = 3'b001;
      repeat (3) step();
      vecs++;
      if ({wr_ready0, rd_ready0, rsp_valid0, ram_wr_en0, init_done0} !== 8'b0) begin
         errs++;
         $display("FAIL reset_u0_ctl got %b exp 0",
                  {wr_ready0, rd_ready0, rsp_valid0, ram_wr_en0, init_done0});
      end
      vecs++;
      if ({ram_wr_addr0, ram_wr_data0, ram_rd_addr0} !== 22'b0) begin
         errs++;
         $display("FAIL reset_u0_ram got %h exp 0",
                  {ram_wr_addr0, ram_wr_data0, ram_rd_addr0});
      end
      vecs++;
      if ({wr_ready1, rd_ready1, rsp_valid1, init_done1} !== 10'b0000000001) begin
         errs++;
         $display("FAIL reset_u1 got %b exp 0000000001",
                  {wr_ready1, rd_ready1, rsp_valid1, init_done1});
      end
      wr_valid0 = '0; rd_valid0 = '0; wr_valid1 = '0; rd_valid1 = '0;
   endtask

   task automatic test_init();
      wr_valid0 = 2'b01;
      rst = 1'b0;
      for (int k = 0; k < 128; k++) begin
         step();
         vecs++;
         if ({ram_wr_en0, ram_wr_addr0, ram_wr_data0, ram_wr_be0, init_done0}
             !== {1'b1, 7'(k), 8'h00, 1'b1, (k == 127)}) begin
            errs++;
            $display("FAIL init_seq k=%0d got en=%b a=%0d d=%h be=%b done=%b",
                     k, ram_wr_en0, ram_wr_addr0, ram_wr_data0, ram_wr_be0, init_done0);
         end
         vecs++;
         if (wr_ready0 !== ((k == 127) ? 2'b01 : 2'b00)) begin
            errs++;
            $display("FAIL init_ready k=%0d got %b", k, wr_ready0);
         end
      end
      wr_valid0 = '0;
      step();
      vecs++;
      if ({ram_wr_en0, init_done0} !== 2'b01) begin
         errs++;
         $display("FAIL init_end got %b exp 01", {ram_wr_en0, init_done0});
      end
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 128; i++) begin
         step();
         if (i > 0) begin
            vecs++;
            if ({ram_wr_en0, ram_wr_addr0, ram_wr_data0}
                !== {1'b1, 7'(i - 1), 8'hFF - 8'(i - 1)}) begin
               errs++;
               $display("FAIL wr_ram i=%0d got en=%b a=%0d d=%h", i,
                        ram_wr_en0, ram_wr_addr0, ram_wr_data0);
            end
         end
         wr_valid0 = 2'b01; wr_addr0 = 14'(i); wr_data0 = 16'(8'hFF - 8'(i));
         #1;
         vecs++;
         if (wr_ready0 !== 2'b01) begin
            errs++;
            $display("FAIL wr_ready i=%0d got %b exp 01", i, wr_ready0);
         end
      end
      step();
      wr_valid0 = '0;
      vecs++;
      if ({ram_wr_en0, ram_wr_addr0, ram_wr_data0} !== {1'b1, 7'd127, 8'h80}) begin
         errs++;
         $display("FAIL wr_ram_last got %b/%0d/%h", ram_wr_en0, ram_wr_addr0, ram_wr_data0);
      end
      e.delete(); q0.delete();
      for (int i = 0; i < 128; i++) begin
         rd_valid0 = 2'b01; rd_addr0 = 14'(i);
         #1;
         vecs++;
         if (rd_ready0 !== 2'b01) begin
            errs++;
            $display("FAIL rd_ready i=%0d got %b exp 01", i, rd_ready0);
         end
         e.push_back('{cyc + 2, 3'b001, 8'hFF - 8'(i)});
         step();
      end
      rd_valid0 = '0;
      repeat (4) step();
      vecs++;
      if (q0.size() != e.size()) begin
         errs++;
         $display("FAIL rd_count got %0d exp %0d", q0.size(), e.size());
      end else begin
         foreach (e[i]) begin
            vecs++;
            if (q0[i].c !== e[i].c || q0[i].v !== e[i].v || q0[i].d !== e[i].d) begin
               errs++;
               $display("FAIL rd_rsp[%0d] got c=%0d v=%b d=%h exp c=%0d v=%b d=%h", i,
                        q0[i].c, q0[i].v, q0[i].d, e[i].c, e[i].v, e[i].d);
            end
         end
      end
   endtask

   // rd_ptr is 1 after the req0-only reads, so req1 wins first
   task automatic test_back_to_back();
      e.delete(); q0.delete();
      rd_valid0 = 2'b11; rd_addr0 = {7'd100, 7'd3};
      for (int k = 0; k < 8; k++) begin
         logic [1:0] g;
         g = (k % 2 == 0) ? 2'b10 : 2'b01;
         #1;
         vecs++;
         if (rd_ready0 !== g) begin
            errs++;
            $display("FAIL b2b_grant k=%0d got %b exp %b", k, rd_ready0, g);
         end
         e.push_back('{cyc + 2, {1'b0, g}, (g == 2'b10) ? 8'h9B : 8'hFC});
         step();
      end
      rd_valid0 = '0;
      repeat (4) step();
      vecs++;
      if (q0.size() != e.size()) begin
         errs++;
         $display("FAIL b2b_count got %0d exp %0d", q0.size(), e.size());
      end else begin
         foreach (e[i]) begin
            vecs++;
            if (q0[i].c !== e[i].c || q0[i].v !== e[i].v || q0[i].d !== e[i].d) begin
               errs++;
               $display("FAIL b2b_rsp[%0d] got c=%0d v=%b d=%h exp c=%0d v=%b d=%h", i,
                        q0[i].c, q0[i].v, q0[i].d, e[i].c, e[i].v, e[i].d);
            end
         end
      end
   endtask

   // addr 5 currently holds 8'hFA
   task automatic test_collision();
      e.delete(); q0.delete();
      wr_valid0 = 2'b01; wr_addr0 = 14'd5; wr_data0 = 16'h00A5;
      rd_valid0 = 2'b10; rd_addr0 = {7'd5, 7'd0};
      #1;
`ifdef DRM_ARB_COLLISION_STALL_EN
      vecs++;
      if ({wr_ready0, rd_ready0} !== 4'b0100) begin
         errs++;
         $display("FAIL coll_stall got %b exp 0100", {wr_ready0, rd_ready0});
      end
      step();
      wr_valid0 = '0;
      #1;
      vecs++;
      if (rd_ready0 !== 2'b10) begin
         errs++;
         $display("FAIL coll_retry got %b exp 10", rd_ready0);
      end
      e.push_back('{cyc + 2, 3'b010, 8'hA5});
      step();
      rd_valid0 = '0;
`else
      vecs++;
      if ({wr_ready0, rd_ready0} !== 4'b0110) begin
         errs++;
         $display("FAIL coll_both got %b exp 0110", {wr_ready0, rd_ready0});
      end
      e.push_back('{cyc + 2, 3'b010, 8'hFA});
      step();
      wr_valid0 = '0; rd_valid0 = '0;
`endif
      repeat (4) step();
      vecs++;
      if (q0.size() != 1) begin
         errs++;
         $display("FAIL coll_count got %0d exp 1", q0.size());
      end else begin
         vecs++;
         if (q0[0].c !== e[0].c || q0[0].v !== e[0].v || q0[0].d !== e[0].d) begin
            errs++;
            $display("FAIL coll_rsp got c=%0d v=%b d=%h exp c=%0d v=%b d=%h",
                     q0[0].c, q0[0].v, q0[0].d, e[0].c, e[0].v, e[0].d);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int r;
      int late;
      q0.delete(); q1.delete(); e.delete();
      rd_valid0 = 2'b01; rd_addr0 = 14'd1;
      rd_valid1 = 3'b001; rd_addr1 = 21'd0;
      for (int k = 0; k < 2; k++) begin
         #1;
         vecs++;
         if ({rd_ready0, rd_ready1} !== 5'b01001) begin
            errs++;
            $display("FAIL rst_pre_rd k=%0d got %b exp 01001", k, {rd_ready0, rd_ready1});
         end
         step();
         rd_addr0 = 14'd2; rd_addr1 = 21'd1;
      end
      r = cyc;
      rst = 1'b1;
      #1;
      vecs++;
      if ({rd_ready0, rd_ready1} !== 5'b0) begin
         errs++;
         $display("FAIL rst_ready got %b exp 0", {rd_ready0, rd_ready1});
      end
      repeat (2) step();
      rd_valid1 = '0;
      rst = 1'b0;
      for (int k = 0; k < 128; k++) begin
         step();
         vecs++;
         if ({init_done0, rd_ready0} !== ((k == 127) ? 3'b101 : 3'b000)) begin
            errs++;
            $display("FAIL reinit k=%0d got %b", k, {init_done0, rd_ready0});
         end
      end
      rd_valid0 = '0;
      late = 0;
      foreach (q0[i]) if (q0[i].c > r) late++;
      foreach (q1[i]) if (q1[i].c > r) late++;
      vecs++;
      if (late != 0) begin
         errs++;
         $display("FAIL rst_flush got %0d late responses exp 0", late);
      end
      step();
      q0.delete();
      rd_valid0 = 2'b01; rd_addr0 = 14'd5;
      #1;
      e.push_back('{cyc + 2, 3'b001, 8'h00});
      step();
      rd_valid0 = '0;
      repeat (3) step();
      vecs++;
      if (q0.size() != 1 || q0[0].c !== e[0].c || q0[0].v !== e[0].v
          || q0[0].d !== e[0].d) begin
         errs++;
         $display("FAIL reinit_zero got n=%0d d=%h exp n=1 c=%0d d=00",
                  q0.size(), (q0.size() > 0) ? q0[0].d : 8'hxx, e[0].c);
      end
   endtask

   task automatic test_nreq3_single();
      e.delete(); q1.delete();
      wr_valid1 = 3'b001; wr_addr1 = 21'd39; wr_data1 = 24'h000011;
      #1;
      vecs++;
      if (wr_ready1 !== 3'b001) begin
         errs++;
         $display("FAIL n3_wr0 got %b exp 001", wr_ready1);
      end
      step();
      wr_valid1 = 3'b100;
      for (int k = 0; k < 4; k++) begin
         wr_addr1 = {7'(40 + k), 14'd0};
         wr_data1 = {8'(8'h50 + k), 16'd0};
         #1;
         vecs++;
         if (wr_ready1 !== 3'b100) begin
            errs++;
            $display("FAIL n3_wr2 k=%0d got %b exp 100", k, wr_ready1);
         end
         step();
      end
      wr_valid1 = '0;
      rd_valid1 = 3'b001; rd_addr1 = 21'd39;
      #1;
      vecs++;
      if (rd_ready1 !== 3'b001) begin
         errs++;
         $display("FAIL n3_rd0 got %b exp 001", rd_ready1);
      end
      e.push_back('{cyc + 3, 3'b001, 8'h11});
      step();
      rd_valid1 = 3'b100;
      for (int k = 0; k < 4; k++) begin
         rd_addr1 = {7'(40 + k), 14'd0};
         #1;
         vecs++;
         if (rd_ready1 !== 3'b100) begin
            errs++;
            $display("FAIL n3_rd2 k=%0d got %b exp 100", k, rd_ready1);
         end
         e.push_back('{cyc + 3, 3'b100, 8'(8'h50 + k)});
         step();
      end
      rd_valid1 = '0;
      repeat (5) step();
      vecs++;
      if (q1.size() != e.size()) begin
         errs++;
         $display("FAIL n3_count got %0d exp %0d", q1.size(), e.size());
      end else begin
         foreach (e[i]) begin
            vecs++;
            if (q1[i].c !== e[i].c || q1[i].v !== e[i].v || q1[i].d !== e[i].d) begin
               errs++;
               $display("FAIL n3_rsp[%0d] got c=%0d v=%b d=%h exp c=%0d v=%b d=%h", i,
                        q1[i].c, q1[i].v, q1[i].d, e[i].c, e[i].v, e[i].d);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init();
      test_write_read();
      test_back_to_back();
      test_collision();
      test_reset_midflight();
      test_nreq3_single();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
